priority_irq_ctrl: RTL and testbench
====================================

# priority_irq_ctrl

Parametrised, registered priority encoder with request latching and an acknowledge handshake. It generalises the 8-to-3 active-low encoder (enable, group-select, enable-out) to N inputs. Short request pulses are captured as pending bits and held until acknowledged, so no request is lost. It sits between peripheral request lines and the consumer that services them, and presents one encoded winner per cycle.

## Interface
- N, 8, number of request inputs; legal range 2..256, need not be a power of two
- W, $clog2(N), index width; derived localparam, not overridable
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- E  input  1  active-low enable
- I  input  N  active-low request lines; I[k]=0 requests service for index k
- ack  input  1  active-high acknowledge of the index currently on A
- A  output  W  registered encoded index of the winning pending request
- GS  output  1  registered, active-low; 0 when A is valid
- EO  output  1  registered, active-low; 0 when enabled and nothing is pending
- pend  output  N  registered pending vector, active-high; for debug and verification

## Operation
- Capture: every cycle, pend_next = (pend & ~clr) | ~I. clr is a one-hot mask at the current A when ack=1 and GS=0; otherwise clr is 0.
- Set wins: if I[k]=0 in the same cycle that index k is acknowledged, pend[k] stays 1.
- Capture continues while disabled (E=1). Requests are never dropped.
- Winner selection, fixed mode: the lowest set index of pend_next wins.
- Output register update at each edge, using pend_next:
  - E=1: A=all-ones truncated to W bits (N-1 when N is a power of two), GS=1, EO=1. ack is ignored.
  - E=0 with pend_next nonzero: A=winner, GS=0, EO=1.
  - E=0 with pend_next zero: A=all-ones, GS=1, EO=0.
- ack with GS=1 has no effect.
- A holds the same value while its pending bit stays set and no higher-priority bit arrives. A higher-priority arrival preempts A at the next edge. The consumer must sample A in the same cycle it asserts ack.
- Arithmetic: all index math is modulo N. Indices ≥ N are never produced, except the all-ones idle code.

## Timing
- Reset (asynchronous, rst_n=0): pend=0, A=all-ones, GS=1, EO=1; round-robin pointer=0.
- The first edge after reset release evaluates normally. With E=0 and no requests, EO=0 after that first edge.
- Latency: I[k] low at edge t makes pend[k]=1, and A/GS reflect it at edge t, i.e. visible in cycle t+1. A one-cycle pulse is sufficient.
- ack at edge t clears pend[A]. The next winner is on A in cycle t+1, giving back-to-back service at one grant per cycle.
- When E toggles 1→0, outputs reflect pend at the next edge. No pending state is lost.
- If reset is asserted mid-operation, all pending bits are discarded immediately.

## Configuration
- PRIO_RR_EN defined: round-robin mode.
  - A W-bit pointer ptr starts the search: the winner is the first set bit at index ptr, ptr+1, … wrapping at N.
  - A qualified ack sets ptr to (A+1) mod N.
  - Unacked cycles leave ptr unchanged.
  - Reset value of ptr is 0.
- PRIO_RR_EN undefined: fixed priority, index 0 highest. There is no pointer register.

## Structure
- Shared package priority_pkg holds:
  - the idle-code function idle_code(W), which returns all-ones
  - the onehot(idx, N) function used for clr
- One sub-module, prio_find_first: combinational. Inputs are vec[N] and start[W]. Outputs are the found index and an any flag.
  - In fixed mode, start is tied to 0.

## Test plan
- Reset, then E=0 with I all-ones → after the first edge A=7, GS=1, EO=0, pend=0 (N=8).
- One-cycle pulse I=8'b1101_0111 (indices 3 and 5) → A=3, GS=0. ack → A=5 next cycle. ack → GS=1, EO=0.
- Pending index 5, and in the same cycle I[5]=0 with ack=1 → pend[5] stays 1 and A=5 again.
- E=1 while I[2] pulses, then E=0 → outputs hold 7/1/1 while disabled. Next cycle A=2, GS=0. ack while E=1 does not clear pend.
- PRIO_RR_EN, N=8, indices 1, 3, 6 pending continuously (held low) with ack every cycle → A sequence 1, 3, 6, 1, 3, 6; ptr wraps.
- N=5, index 4 pending → A=4. rst_n pulsed low mid-stream → pend=0, A=7, GS=1, EO=1 immediately.

Source files
------------

// File: rtl/priority_pkg.sv
// Shared helpers for priority_irq_ctrl: idle-code and one-hot mask generation.
package priority_pkg;

  localparam int unsigned MAX_N = 256;

  // All-ones code of the given width; callers cast down to their index width.
  function automatic logic [7:0] idle_code(input int unsigned w);
    logic [8:0] v_s;
    v_s = (9'd1 << w) - 9'd1;
    return v_s[7:0];
  endfunction

  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_N-1:0] v_s;
    if (idx < n) begin
      v_s = {{(MAX_N-1){1'b0}}, 1'b1} << idx;
    end else begin
      v_s = '0;
    end
    return v_s;
  endfunction

endpackage

// File: rtl/prio_find_first.sv
// Combinational search for the first set bit of vec, starting at index start
// and wrapping at N.
module prio_find_first #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from the farthest offset down so the nearest set bit is assigned last.
  always_comb begin
    int p;
    p   = 0;
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      p = (int'(start) + i) % N;
      if (vec[W'(p)]) begin
        idx = W'(p);
        any = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/priority_irq_ctrl.sv
// Registered N-input active-low priority encoder with request latching and ack.
// Define PRIO_RR_EN for round-robin arbitration; otherwise index 0 always wins.
module priority_irq_ctrl
  import priority_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         E,
  input  logic [N-1:0] I,
  input  logic         ack,
  output logic [W-1:0] A,
  output logic         GS,
  output logic         EO,
  output logic [N-1:0] pend
);

  logic [N-1:0] r_pend;
  logic [W-1:0] r_a;
  logic         r_gs;
  logic         r_eo;

  logic         w_qual_ack;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_pend_next;
  logic [W-1:0] w_start;
  logic [W-1:0] w_idx;
  logic         w_any;
  logic [W-1:0] w_idle;

  assign w_idle = W'(idle_code(W));

  // Ack only counts while enabled and a valid index is presented; new requests beat the clear.
  always_comb begin
    w_qual_ack  = ack & ~r_gs & ~E;
    if (w_qual_ack) begin
      w_clr = N'(onehot(32'(r_a), N));
    end else begin
      w_clr = '0;
    end
    w_pend_next = (r_pend & ~w_clr) | ~I;
  end

`ifdef PRIO_RR_EN
  logic [W-1:0] r_ptr;
  logic [W-1:0] w_ptr_next;

  // The search for this edge already starts past the index being acknowledged.
  always_comb begin
    if (w_qual_ack) begin
      if ((32'(r_a) + 32'd1) >= 32'(N)) begin
        w_ptr_next = '0;
      end else begin
        w_ptr_next = r_a + W'(1);
      end
    end else begin
      w_ptr_next = r_ptr;
    end
  end

  // Round-robin start pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  assign w_start = w_ptr_next;
`else
  assign w_start = '0;
`endif

  prio_find_first #(.N(N)) u_find (
    .vec   (w_pend_next),
    .start (w_start),
    .idx   (w_idx),
    .any   (w_any)
  );

  // Pending vector and encoded outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_a    <= w_idle;
      r_gs   <= 1'b1;
      r_eo   <= 1'b1;
    end else begin
      r_pend <= w_pend_next;
      if (E) begin
        r_a  <= w_idle;
        r_gs <= 1'b1;
        r_eo <= 1'b1;
      end else if (w_any) begin
        r_a  <= w_idx;
        r_gs <= 1'b0;
        r_eo <= 1'b1;
      end else begin
        r_a  <= w_idle;
        r_gs <= 1'b1;
        r_eo <= 1'b0;
      end
    end
  end

  assign A    = r_a;
  assign GS   = r_gs;
  assign EO   = r_eo;
  assign pend = r_pend;

endmodule

// File: tb/tb_priority_irq_ctrl.sv
// Table-driven, scoreboard-checked bench for priority_irq_ctrl (N=8 and N=5).
module tb_priority_irq_ctrl;

  typedef struct packed {
    logic       e;
    logic [7:0] i;
    logic       ack;
    logic [2:0] a;
    logic       gs;
    logic       eo;
    logic [7:0] pend;
  } vec_t;

  typedef struct packed {
    logic [2:0] a;
    logic       gs;
    logic       eo;
    logic [7:0] pend;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, rst5_n;
  logic       E8, ack8, E5, ack5;
  logic [7:0] I8, pend8;
  logic [4:0] I5, pend5;
  logic [2:0] A8, A5;
  logic       GS8, EO8, GS5, EO5;

  exp_t sbq[$];
  exp_t sbq5[$];
  vec_t tbl[13];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  priority_irq_ctrl #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .E(E8), .I(I8), .ack(ack8),
    .A(A8), .GS(GS8), .EO(EO8), .pend(pend8)
  );

  priority_irq_ctrl #(.N(5)) u5 (
    .clk(clk), .rst_n(rst5_n), .E(E5), .I(I5), .ack(ack5),
    .A(A5), .GS(GS5), .EO(EO5), .pend(pend5)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk8(input string tag, input exp_t ex);
    chk({tag, ".A"},    32'(A8),    32'(ex.a));
    chk({tag, ".GS"},   32'(GS8),   32'(ex.gs));
    chk({tag, ".EO"},   32'(EO8),   32'(ex.eo));
    chk({tag, ".pend"}, 32'(pend8), 32'(ex.pend));
  endtask

  task automatic chk5(input string tag, input exp_t ex);
    chk({tag, ".A"},    32'(A5),    32'(ex.a));
    chk({tag, ".GS"},   32'(GS5),   32'(ex.gs));
    chk({tag, ".EO"},   32'(EO5),   32'(ex.eo));
    chk({tag, ".pend"}, 32'(pend5), 32'(ex.pend[4:0]));
  endtask

  task automatic step8(input string tag, input logic e, input logic [7:0] i, input logic ack,
                       input exp_t ex);
    exp_t got;
    E8 = e; I8 = i; ack8 = ack;
    sbq.push_back(ex);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      got = sbq.pop_front();
      chk8(tag, got);
    end
  endtask

  task automatic step5(input string tag, input logic e, input logic [4:0] i, input logic ack,
                       input exp_t ex);
    exp_t got;
    E5 = e; I5 = i; ack5 = ack;
    sbq5.push_back(ex);
    @(posedge clk);
    #1;
    if (sbq5.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      got = sbq5.pop_front();
      chk5(tag, got);
    end
  endtask

  initial begin
    logic [2:0] rr_seq [6];
    // e, I, ack -> A, GS, EO, pend
    tbl[0]  = '{1'b0, 8'hFF, 1'b0, 3'd7, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'hD7, 1'b0, 3'd3, 1'b0, 1'b1, 8'h28};
    tbl[2]  = '{1'b0, 8'hFF, 1'b1, 3'd5, 1'b0, 1'b1, 8'h20};
    tbl[3]  = '{1'b0, 8'hFF, 1'b1, 3'd7, 1'b1, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 8'hDF, 1'b0, 3'd5, 1'b0, 1'b1, 8'h20};
    tbl[5]  = '{1'b0, 8'hDF, 1'b1, 3'd5, 1'b0, 1'b1, 8'h20};
    tbl[6]  = '{1'b0, 8'hFF, 1'b1, 3'd7, 1'b1, 1'b0, 8'h00};
    tbl[7]  = '{1'b1, 8'hFB, 1'b0, 3'd7, 1'b1, 1'b1, 8'h04};
    tbl[8]  = '{1'b1, 8'hFF, 1'b1, 3'd7, 1'b1, 1'b1, 8'h04};
    tbl[9]  = '{1'b0, 8'hFF, 1'b0, 3'd2, 1'b0, 1'b1, 8'h04};
    tbl[10] = '{1'b0, 8'hFE, 1'b0, 3'd0, 1'b0, 1'b1, 8'h05};
    tbl[11] = '{1'b0, 8'hFF, 1'b1, 3'd2, 1'b0, 1'b1, 8'h04};
    tbl[12] = '{1'b0, 8'hFF, 1'b1, 3'd7, 1'b1, 1'b0, 8'h00};

`ifdef PRIO_RR_EN
    rr_seq = '{3'd1, 3'd3, 3'd6, 3'd1, 3'd3, 3'd6};
`else
    rr_seq = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
`endif

    rst_n = 1'b0; rst5_n = 1'b0;
    E8 = 1'b1; I8 = 8'hFF; ack8 = 1'b0;
    E5 = 1'b1; I5 = 5'h1F; ack5 = 1'b0;
    @(posedge clk);
    #1;
    chk8("reset8", '{3'd7, 1'b1, 1'b1, 8'h00});
    chk5("reset5", '{3'd7, 1'b1, 1'b1, 8'h00});
    rst_n = 1'b1; rst5_n = 1'b1;

    for (int k = 0; k < 13; k++) begin
      step8($sformatf("tbl%0d", k), tbl[k].e, tbl[k].i, tbl[k].ack,
            '{tbl[k].a, tbl[k].gs, tbl[k].eo, tbl[k].pend});
    end

    // Fresh pointer for the rotation sequence.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step8("rr0", 1'b0, 8'hB5, 1'b0, '{rr_seq[0], 1'b0, 1'b1, 8'h4A});
    for (int k = 1; k < 6; k++) begin
      step8($sformatf("rr%0d", k), 1'b0, 8'hB5, 1'b1, '{rr_seq[k], 1'b0, 1'b1, 8'h4A});
    end

    // Asynchronous reset with requests pending: cleared without any clock edge.
    rst_n = 1'b0;
    #1;
    chk8("async8", '{3'd7, 1'b1, 1'b1, 8'h00});
    #1;
    rst_n = 1'b1;
    step8("post_rst8", 1'b0, 8'hFF, 1'b0, '{3'd7, 1'b1, 1'b0, 8'h00});

    E8 = 1'b1;
    step5("n5_idle", 1'b0, 5'h1F, 1'b0, '{3'd7, 1'b1, 1'b0, 8'h00});
    step5("n5_req4", 1'b0, 5'h0F, 1'b0, '{3'd4, 1'b0, 1'b1, 8'h10});
    step5("n5_hold", 1'b0, 5'h1F, 1'b0, '{3'd4, 1'b0, 1'b1, 8'h10});
    step5("n5_ack4", 1'b0, 5'h1F, 1'b1, '{3'd7, 1'b1, 1'b0, 8'h00});
    step5("n5_req4b", 1'b0, 5'h0F, 1'b0, '{3'd4, 1'b0, 1'b1, 8'h10});
    rst5_n = 1'b0;
    #1;
    chk5("async5", '{3'd7, 1'b1, 1'b1, 8'h00});
    #1;
    rst5_n = 1'b1;

    chk("queues_empty", 32'(sbq.size() + sbq5.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
